// File: rtl/lab_pkg.sv
// Shared encodings and helpers for the lab's counter and sequencer blocks.
package lab_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic ENC_BIN  = 1'b0;
    localparam logic ENC_GRAY = 1'b1;

    // All-ones value of a width-bit count; the shift wraps to zero at 32 so the
    // subtraction still yields all ones.
    function automatic int unsigned max_val(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Purely combinational binary-to-reflected-Gray conversion.
module bin2gray #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with load, wrap/saturate policy, terminal count
// and a registered boundary-event pulse; output selectable binary or Gray.
module param_updown_counter
    import lab_pkg::*;
#(
    parameter int unsigned      WIDTH     = 3,
    parameter bit               WRAP      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             gray_sel,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic [WIDTH-1:0] cnt_gray;
    logic             at_max;
    logic             at_min;

    assign at_max = (cnt == MAX);
    assign at_min = (cnt == '0);

    // High when the coming edge will attempt to step past a boundary.
    assign tc = en & ~load & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_min));

    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = 1'b0;
        if (load) begin
            cnt_nxt = din;
        end else if (en) begin
            ovf_nxt = tc;
            // Saturating policy holds at the boundary; wrap falls out of modulo arithmetic.
            if (!(tc && !WRAP)) begin
                cnt_nxt = (dir == DIR_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            cnt <= RESET_VAL;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (cnt),
        .gray (cnt_gray)
    );

    assign q = (gray_sel == ENC_GRAY) ? cnt_gray : cnt;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: wrap, saturate and non-zero reset variants.
module tb_param_updown_counter;

    logic       clck = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] din = 3'd0;
    logic       gray_sel = 1'b0;

    logic [2:0] q_w, q_s, q_r;
    logic       tc_w, tc_s, tc_r;
    logic       ovf_w, ovf_s, ovf_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clck = ~clck;

    param_updown_counter #(.WIDTH(3), .WRAP(1'b1), .RESET_VAL(3'd0)) u_wrap (
        .clck(clck), .rst(rst), .en(en), .dir(dir), .load(load), .din(din),
        .gray_sel(gray_sel), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    param_updown_counter #(.WIDTH(3), .WRAP(1'b0), .RESET_VAL(3'd0)) u_sat (
        .clck(clck), .rst(rst), .en(en), .dir(dir), .load(load), .din(din),
        .gray_sel(gray_sel), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    param_updown_counter #(.WIDTH(3), .WRAP(1'b1), .RESET_VAL(3'd3)) u_rv3 (
        .clck(clck), .rst(rst), .en(en), .dir(dir), .load(load), .din(din),
        .gray_sel(gray_sel), .q(q_r), .tc(tc_r), .ovf(ovf_r)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       dir;
        logic       gray;
        logic [2:0] din;
        logic       tc;   // expected before the edge
        logic [2:0] q;    // expected after the edge
        logic       ovf;  // expected after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic l, input logic e, input logic d,
                                input logic g, input logic [2:0] di,
                                input logic t, input logic [2:0] qq, input logic o);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.dir = d; v.gray = g; v.din = di;
        v.tc = t; v.q = qq; v.ovf = o;
        return v;
    endfunction

    task automatic chk_bit(input string nm, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    // Drive inputs mid-low phase so combinational tc can be sampled before the edge.
    task automatic drive(input logic r, input logic l, input logic e, input logic d,
                         input logic g, input logic [2:0] di);
        @(negedge clck);
        rst = r; load = l; en = e; dir = d; gray_sel = g; din = di;
        #1;
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // r l e d g din   tc q ovf
        vecs.push_back(mk(1,0,0,0,0,3'd0, 0,3'd0,0));   // reset
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd1,0));   // binary up sweep
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd2,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd3,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd4,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd5,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd6,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd7,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 1,3'd0,1));   // wrap 7->0
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b001,0)); // Gray up sweep
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b011,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b010,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b110,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b111,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b101,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b100,0));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 1,3'b000,1));
        vecs.push_back(mk(0,0,1,0,1,3'd0, 0,3'b001,0)); // ovf drops after one cycle
        vecs.push_back(mk(0,1,1,0,0,3'd5, 0,3'd5,0));   // load beats en
        vecs.push_back(mk(0,0,0,0,0,3'd0, 0,3'd5,0));   // hold
        vecs.push_back(mk(0,0,0,1,1,3'd3, 0,3'b111,0)); // hold, view as Gray
        vecs.push_back(mk(0,0,0,0,0,3'd6, 0,3'd5,0));   // back to binary, cnt untouched
        vecs.push_back(mk(1,1,1,0,0,3'd6, 0,3'd0,0));   // rst beats load
        vecs.push_back(mk(0,1,0,0,0,3'd7, 0,3'd7,0));
        vecs.push_back(mk(0,0,0,0,0,3'd0, 0,3'd7,0));   // at MAX but disabled: no tc
        vecs.push_back(mk(0,1,1,0,0,3'd2, 0,3'd2,0));   // load masks boundary at MAX
        vecs.push_back(mk(0,1,0,0,0,3'd1, 0,3'd1,0));
        vecs.push_back(mk(0,0,1,1,0,3'd0, 0,3'd0,0));   // down sweep
        vecs.push_back(mk(0,0,1,1,0,3'd0, 1,3'd7,1));   // underflow wrap 0->7
        vecs.push_back(mk(0,0,1,1,0,3'd0, 0,3'd6,0));
        vecs.push_back(mk(0,0,1,0,0,3'd0, 0,3'd7,0));   // immediate direction change
        vecs.push_back(mk(0,0,1,1,0,3'd0, 0,3'd6,0));   // down at MAX: no tc

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].dir, vecs[i].gray, vecs[i].din);
            if (i > 0) chk_bit("vec_tc", i, tc_w, vecs[i].tc);
            tick();
            chk_q("vec_q", i, q_w, vecs[i].q);
            chk_bit("vec_ovf", i, ovf_w, vecs[i].ovf);
        end

        // Common reset; the RESET_VAL=3 instance must come up at 3.
        drive(1,0,0,0,0,3'd0);
        tick();
        chk_q("sat_rst_q", 0, q_s, 3'd0);
        chk_q("rv3_rst_q", 0, q_r, 3'd3);
        chk_bit("rv3_rst_ovf", 0, ovf_r, 1'b0);
        drive(0,0,0,0,1,3'd0);
        chk_q("rv3_rst_gray", 0, q_r, 3'b010);

        // Saturation: up from 6, three attempts past MAX.
        drive(0,1,0,0,0,3'd6);
        tick();
        chk_q("sat_load", 0, q_s, 3'd6);
        for (int k = 0; k < 4; k++) begin
            drive(0,0,1,0,0,3'd0);
            chk_bit("sat_tc", k, tc_s, (k != 0));
            tick();
            chk_q("sat_q", k, q_s, 3'd7);
            chk_bit("sat_ovf", k, ovf_s, (k != 0));
        end
        drive(0,0,1,1,0,3'd0);
        chk_bit("sat_rev_tc", 0, tc_s, 1'b0);
        tick();
        chk_q("sat_rev_q", 0, q_s, 3'd6);
        chk_bit("sat_rev_ovf", 0, ovf_s, 1'b0);

        // Mid-count reset to RESET_VAL=3, then counting resumes from it.
        drive(0,1,0,0,0,3'd5);
        tick();
        chk_q("rv3_load", 0, q_r, 3'd5);
        drive(0,0,1,1,0,3'd0);
        tick();
        chk_q("rv3_down", 0, q_r, 3'd4);
        drive(1,1,1,1,0,3'd6);
        tick();
        chk_q("rv3_midrst_q", 0, q_r, 3'd3);
        chk_bit("rv3_midrst_ovf", 0, ovf_r, 1'b0);
        drive(0,0,1,1,0,3'd0);
        tick();
        chk_q("rv3_resume", 0, q_r, 3'd2);
        chk_bit("rv3_resume_ovf", 0, ovf_r, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
